// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle target for the LDUR/STUR data-memory port.
// One request at a time is accepted over a valid/ready handshake, held for a
// programmable number of cycles, then the 64-bit doubleword access is made
// and the response is held until the requester takes it.
module dmem_responder #(
   parameter int LATENCY = 3,   // cycles from acceptance to resp_valid, 1..15
   parameter int DEPTH   = 128  // doublewords of storage, power of two
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);

   localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] LOAD_CNT = 4'(LATENCY - 1);
   localparam logic [60:0] DEPTH_W = 61'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_RESP
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_write;
   logic [63:0] r_addr;
   logic [63:0] r_wdata;
   logic        r_resp_valid;
   logic [63:0] r_resp_rdata;
   logic        r_resp_err;

   // Backing storage; contents are deliberately never reset.
   logic [63:0] r_mem [DEPTH];

   logic          w_err;
   logic          w_access;
   logic          w_mem_we;
   logic [AW-1:0] w_idx;

   // Doubleword index of the latched request; the upper bits only matter
   // for the range check below.
   assign w_idx    = r_addr[AW+2:3];

   // A request is rejected if it is not doubleword aligned or its full
   // 61-bit index lies past the end of storage (no aliasing of high bits).
   assign w_err    = (r_addr[2:0] != 3'b000) || (r_addr[63:3] >= DEPTH_W);

   // The access happens on the edge that leaves BUSY with the counter spent.
   assign w_access = (r_state == S_BUSY) && (r_cnt == 4'd0);

   // Reset at the access edge wins: a store still in BUSY never lands.
   assign w_mem_we = w_access && r_write && !w_err && !reset;

   assign req_ready  = (r_state == S_IDLE) && !reset;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;

   // Storage write port, kept free of reset so it maps onto block RAM.
   always_ff @(posedge CLK) begin
      if (w_mem_we) begin
         r_mem[w_idx] <= r_wdata;
      end
   end

   // Request/response FSM with registered response outputs.
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= 4'd0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 64'd0;
         r_resp_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_write <= req_write;
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  r_cnt   <= LOAD_CNT;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= w_err;
                  // Only an error-free load returns data; stores and
                  // errors return zero.
                  r_resp_rdata <= (!w_err && !r_write) ? r_mem[w_idx] : 64'd0;
                  r_state      <= S_RESP;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=3 for the main
// scenarios and a second at LATENCY=1 for minimum-latency back-to-back.
module tb_dmem_responder;

   localparam int LAT = 3;

   logic        CLK = 1'b0;
   logic        reset;

   logic        req_valid, req_ready, req_write;
   logic [63:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [63:0] resp_rdata;

   logic        req_valid1, req_ready1, req_write1;
   logic [63:0] req_addr1, req_wdata1;
   logic        resp_valid1, resp_ready1, resp_err1;
   logic [63:0] resp_rdata1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   dmem_responder #(.LATENCY(LAT), .DEPTH(128)) dut (
      .CLK        (CLK),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   dmem_responder #(.LATENCY(1), .DEPTH(128)) dut1 (
      .CLK        (CLK),
      .reset      (reset),
      .req_valid  (req_valid1),
      .req_ready  (req_ready1),
      .req_write  (req_write1),
      .req_addr   (req_addr1),
      .req_wdata  (req_wdata1),
      .resp_valid (resp_valid1),
      .resp_ready (resp_ready1),
      .resp_rdata (resp_rdata1),
      .resp_err   (resp_err1)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Issue one request to the LATENCY=3 instance (assumed idle), count edges
   // to resp_valid (bounded), capture the response and complete the handshake.
   task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                         output int lat, output logic [63:0] rd, output logic er);
      req_valid  = 1'b1;
      req_write  = w;
      req_addr   = a;
      req_wdata  = d;
      resp_ready = 1'b0;
      tick();
      req_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (resp_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
      rd = resp_rdata;
      er = resp_err;
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      if (req_ready !== 1'b0) begin
         n_bad++; $display("FAIL rst_ready_in_reset: got %b want 0", req_ready);
      end
      n_cmp++;
      reset = 1'b0;
      #1;
      if (req_ready !== 1'b1) begin
         n_bad++; $display("FAIL rst_ready_after: got %b want 1", req_ready);
      end
      n_cmp++;
      if (resp_valid !== 1'b0) begin
         n_bad++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid);
      end
      n_cmp++;
      if (resp_rdata !== 64'd0) begin
         n_bad++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata);
      end
      n_cmp++;
      if (resp_err !== 1'b0) begin
         n_bad++; $display("FAIL rst_resp_err: got %b want 0", resp_err);
      end
      n_cmp++;
      if (req_ready1 !== 1'b1 || resp_valid1 !== 1'b0) begin
         n_bad++; $display("FAIL rst_lat1: got ready=%b valid=%b want 1/0", req_ready1, resp_valid1);
      end
      n_cmp++;
      $display("reset done");
   endtask

   task automatic test_store_load();
      int          lat;
      logic [63:0] rd;
      logic        er;
      do_req(1'b1, 64'h28, 64'h0123456789ABCDEF, lat, rd, er);
      $display("store 0x28 lat=%0d rdata=%h err=%b", lat, rd, er);
      if (lat !== 3) begin
         n_bad++; $display("FAIL st_latency: got %0d want 3", lat);
      end
      n_cmp++;
      if (rd !== 64'd0 || er !== 1'b0) begin
         n_bad++; $display("FAIL st_resp: got rdata=%h err=%b want 0/0", rd, er);
      end
      n_cmp++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_bad++; $display("FAIL st_handshake: got valid=%b ready=%b want 0/1", resp_valid, req_ready);
      end
      n_cmp++;
      do_req(1'b0, 64'h28, 64'h0, lat, rd, er);
      $display("load 0x28 lat=%0d rdata=%h err=%b", lat, rd, er);
      if (lat !== 3) begin
         n_bad++; $display("FAIL ld_latency: got %0d want 3", lat);
      end
      n_cmp++;
      if (rd !== 64'h0123456789ABCDEF || er !== 1'b0) begin
         n_bad++; $display("FAIL ld_data: got rdata=%h err=%b want 0123456789abcdef/0", rd, er);
      end
      n_cmp++;
   endtask

   task automatic test_backpressure();
      bit got;
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_addr   = 64'h28;
      req_wdata  = 64'h0;
      resp_ready = 1'b0;
      tick();
      req_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (resp_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      if (got !== 1'b1) begin
         n_bad++; $display("FAIL bp_timeout: got no resp_valid want resp_valid");
      end
      n_cmp++;
      // Hold off the response for 5 cycles while a new request is offered.
      req_valid = 1'b1;
      req_addr  = 64'h0;
      for (int c = 0; c < 5; c++) begin
         tick();
         $display("backpressure cycle %0d valid=%b rdata=%h ready=%b", c, resp_valid, resp_rdata, req_ready);
         if (resp_valid !== 1'b1) begin
            n_bad++; $display("FAIL bp_valid_%0d: got %b want 1", c, resp_valid);
         end
         n_cmp++;
         if (resp_rdata !== 64'h0123456789ABCDEF) begin
            n_bad++; $display("FAIL bp_rdata_%0d: got %h want 0123456789abcdef", c, resp_rdata);
         end
         n_cmp++;
         if (req_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp_ready_%0d: got %b want 0", c, req_ready);
         end
         n_cmp++;
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_bad++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", resp_valid, req_ready);
      end
      n_cmp++;
      tick();
      if (req_ready !== 1'b1) begin
         n_bad++; $display("FAIL bp_no_phantom: got ready=%b want 1", req_ready);
      end
      n_cmp++;
   endtask

   task automatic test_errors();
      int          lat;
      logic [63:0] rd;
      logic        er;
      do_req(1'b0, 64'h2C, 64'h0, lat, rd, er);
      $display("load 0x2c rdata=%h err=%b", rd, er);
      if (rd !== 64'd0 || er !== 1'b1) begin
         n_bad++; $display("FAIL err_misaligned: got rdata=%h err=%b want 0/1", rd, er);
      end
      n_cmp++;
      do_req(1'b1, 64'h0, 64'hA0A0, lat, rd, er);
      do_req(1'b1, 64'h3F8, 64'hB0B0, lat, rd, er);
      if (er !== 1'b0) begin
         n_bad++; $display("FAIL err_last_index: got err=%b want 0", er);
      end
      n_cmp++;
      do_req(1'b1, 64'h400, 64'hFF, lat, rd, er);
      $display("store 0x400 rdata=%h err=%b", rd, er);
      if (rd !== 64'd0 || er !== 1'b1) begin
         n_bad++; $display("FAIL err_range: got rdata=%h err=%b want 0/1", rd, er);
      end
      n_cmp++;
      do_req(1'b1, 64'h1_0000_0000, 64'hEE, lat, rd, er);
      if (er !== 1'b1) begin
         n_bad++; $display("FAIL err_high_bits: got err=%b want 1", er);
      end
      n_cmp++;
      do_req(1'b0, 64'h0, 64'h0, lat, rd, er);
      $display("load 0x0 rdata=%h err=%b", rd, er);
      if (rd !== 64'hA0A0 || er !== 1'b0) begin
         n_bad++; $display("FAIL err_idx0_kept: got rdata=%h err=%b want a0a0/0", rd, er);
      end
      n_cmp++;
      do_req(1'b0, 64'h3F8, 64'h0, lat, rd, er);
      $display("load 0x3f8 rdata=%h err=%b", rd, er);
      if (rd !== 64'hB0B0 || er !== 1'b0) begin
         n_bad++; $display("FAIL err_idx127_kept: got rdata=%h err=%b want b0b0/0", rd, er);
      end
      n_cmp++;
   endtask

   task automatic test_reset_busy();
      int          lat;
      logic [63:0] rd;
      logic        er;
      bit          seen;
      do_req(1'b1, 64'h08, 64'h1111, lat, rd, er);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 64'h08;
      req_wdata = 64'hDEAD;
      tick();
      req_valid = 1'b0;
      reset     = 1'b1;
      tick();
      if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
         n_bad++; $display("FAIL rb_in_reset: got ready=%b valid=%b want 0/0", req_ready, resp_valid);
      end
      n_cmp++;
      reset = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (resp_valid !== 1'b0) seen = 1'b1;
      end
      if (seen !== 1'b0) begin
         n_bad++; $display("FAIL rb_no_resp: got resp_valid seen want none");
      end
      n_cmp++;
      do_req(1'b0, 64'h08, 64'h0, lat, rd, er);
      $display("load 0x08 after reset rdata=%h err=%b", rd, er);
      if (rd !== 64'h1111 || er !== 1'b0) begin
         n_bad++; $display("FAIL rb_store_dropped: got rdata=%h err=%b want 1111/0", rd, er);
      end
      n_cmp++;
   endtask

   task automatic test_back_to_back_lat1();
      logic        wv;
      logic [63:0] av, dv, exp_rd;
      logic        exp_er;
      resp_ready1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0: begin wv = 1'b1; av = 64'h28; dv = 64'h55; exp_rd = 64'h0;  exp_er = 1'b0; end
            1: begin wv = 1'b0; av = 64'h28; dv = 64'h0;  exp_rd = 64'h55; exp_er = 1'b0; end
            default: begin wv = 1'b0; av = 64'h2C; dv = 64'h0; exp_rd = 64'h0; exp_er = 1'b1; end
         endcase
         req_valid1 = 1'b1;
         req_write1 = wv;
         req_addr1  = av;
         req_wdata1 = dv;
         if (req_ready1 !== 1'b1) begin
            n_bad++; $display("FAIL l1_ready_%0d: got %b want 1", i, req_ready1);
         end
         n_cmp++;
         tick();
         if (resp_valid1 !== 1'b0 || req_ready1 !== 1'b0) begin
            n_bad++; $display("FAIL l1_busy_%0d: got valid=%b ready=%b want 0/0", i, resp_valid1, req_ready1);
         end
         n_cmp++;
         tick();
         $display("lat1 req %0d addr=%h valid=%b rdata=%h err=%b", i, av, resp_valid1, resp_rdata1, resp_err1);
         if (resp_valid1 !== 1'b1) begin
            n_bad++; $display("FAIL l1_valid_%0d: got %b want 1", i, resp_valid1);
         end
         n_cmp++;
         if (resp_rdata1 !== exp_rd || resp_err1 !== exp_er) begin
            n_bad++; $display("FAIL l1_resp_%0d: got rdata=%h err=%b want %h/%b", i, resp_rdata1, resp_err1, exp_rd, exp_er);
         end
         n_cmp++;
         tick();
         if (resp_valid1 !== 1'b0) begin
            n_bad++; $display("FAIL l1_release_%0d: got %b want 0", i, resp_valid1);
         end
         n_cmp++;
      end
      req_valid1  = 1'b0;
      resp_ready1 = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      req_valid   = 1'b0;
      req_write   = 1'b0;
      req_addr    = 64'h0;
      req_wdata   = 64'h0;
      resp_ready  = 1'b0;
      req_valid1  = 1'b0;
      req_write1  = 1'b0;
      req_addr1   = 64'h0;
      req_wdata1  = 64'h0;
      resp_ready1 = 1'b0;

      test_reset();
      test_store_load();
      test_backpressure();
      test_errors();
      test_reset_busy();
      test_back_to_back_lat1();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder for the processor's load/store port: the target side of the LDUR/STUR memory interface.
- Accepts one request at a time through a valid/ready handshake and waits a programmable access latency.
- Performs the 64-bit doubleword read or write, then presents a response held until the requester accepts it.
- Sits between the processor's data-memory port and backing storage; lets the datapath be exercised against a non-zero-latency memory with stall handshakes.

Parameters:
- LATENCY, 3, cycles from request acceptance to resp_valid assertion; legal range 1..15.
- DEPTH, 128, number of 64-bit doublewords in the storage array; power of two.

Ports:
- CLK  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- req_valid  input  1  requester has a request on req_* this cycle
- req_ready  output  1  responder can accept a request this cycle
- req_write  input  1  1 = store (STUR), 0 = load (LDUR)
- req_addr  input  64  byte address (ALU result)
- req_wdata  input  64  store data (register B value)
- resp_valid  output  1  response available on resp_*
- resp_ready  input  1  requester accepts response this cycle
- resp_rdata  output  64  load data; 0 for stores and errors
- resp_err  output  1  request was misaligned or out of range

Behaviour:
- Reset (reset sampled high at rising CLK):
  - state := IDLE, resp_valid := 0, resp_rdata := 0, resp_err := 0, counter := 0.
  - req_ready is 0 in any cycle where reset is high.
  - Storage contents are not reset; they are undefined until written.
- FSM states: IDLE, BUSY, RESP.
- req_ready = (state == IDLE) && !reset. The request is not accepted in BUSY or RESP.
- IDLE:
  - Acceptance occurs at an edge with req_valid && req_ready.
  - On acceptance, latch req_write, req_addr and req_wdata into internal registers; load counter := LATENCY-1; go to BUSY.
  - req_* inputs are don't-care after acceptance.
- BUSY:
  - If counter != 0: decrement.
  - If counter == 0, at the next edge perform the access, set resp_valid := 1, and go to RESP.
  - For acceptance at edge k, resp_valid rises after edge k+LATENCY.
- Access rules, using the latched request:
  - err = (addr[2:0] != 0) || (addr[63:3] >= DEPTH).
  - Load without error: resp_rdata := mem[addr[63:3]], resp_err := 0.
  - Store without error: mem[addr[63:3]] := wdata, resp_rdata := 0, resp_err := 0.
  - Any error: no storage write, resp_rdata := 0, resp_err := 1.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until an edge with resp_ready = 1.
  - At that edge: resp_valid := 0, go to IDLE. resp_rdata and resp_err keep their values, don't-care while resp_valid = 0.
  - resp_ready asserted in IDLE or BUSY is ignored.
- Throughput: minimum request-to-request spacing is LATENCY+2 cycles (accept, LATENCY cycles, response handshake edge, IDLE).
- Read-after-write: a load issued after a store to the same address completes returns the stored value.
- Reset mid-operation (BUSY or RESP): the pending request is discarded and outputs return to reset values.
  - A store still in BUSY is never written.
  - A store already in RESP has already updated storage.
- The counter width is 4 bits; LATENCY = 1 loads 0 and responds after exactly one edge.

Test Plan:
- Reset then idle: hold reset 2 cycles, release -> req_ready = 1 on the first non-reset cycle; resp_valid = 0, resp_rdata = 0, resp_err = 0.
- Store/load round trip (LATENCY = 3):
  - Store addr 0x28, data 0x0123456789ABCDEF accepted at edge k -> resp_valid rises after edge k+3 with resp_err = 0 and resp_rdata = 0.
  - resp_ready = 1 -> IDLE.
  - Load 0x28 -> resp_rdata = 0x0123456789ABCDEF.
- Backpressure: load completes with resp_ready = 0 for 5 cycles -> resp_valid and resp_rdata are held constant and req_ready = 0 throughout; the single resp_ready pulse clears resp_valid at that edge.
- Errors: load addr 0x2C (misaligned) -> resp_err = 1, resp_rdata = 0; store 0x400 (DEPTH = 128, index 128) with data 0xFF -> resp_err = 1 and storage unchanged (indices 0 and 127 are read back and must be unchanged).
- Reset mid-BUSY: store addr 0x08, data 0xDEAD; assert reset one cycle after acceptance -> no resp_valid; a subsequent load of 0x08 returns its prior value (0x1111 written beforehand).
- LATENCY = 1 build: accept load at edge k -> resp_valid after edge k+1; back-to-back requests are accepted every 3 cycles with resp_ready held high.
